temporizador_multicanal: RTL and testbench

Parametrised multi-channel interval timer, successor to the single-channel switch-reset timer. Each of `N_CANAIS` channels counts a programmable number of prescaled ticks and signals expiry, in either one-shot or periodic mode. It sits between board-level controls or a register interface and the indicator/LED and sequencing logic of the factory-floor design.

---
 rtl/temporizador_multicanal.sv | 124 ++++++++++++
 tb/tb_temporizador_multicanal.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/temporizador_multicanal.sv
// Multi-channel interval timer: per-channel prescaler, tick counter and
// one-shot/periodic expiry with registered busy/done/pulse outputs.
module temporizador_multicanal #(
    parameter int N_CANAIS      = 4,
    parameter int WIDTH         = 32,
    parameter int PRESC         = 1,
    parameter int INTERVALO_DEF = 100000000,
    localparam int CW = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CANAIS-1:0] start,
    input  logic [N_CANAIS-1:0] stop,
    input  logic [N_CANAIS-1:0] modo,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [N_CANAIS-1:0] busy,
    output logic [N_CANAIS-1:0] done,
    output logic [N_CANAIS-1:0] pulse
);

    localparam int PW = $clog2(PRESC + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESC - 1);
    localparam logic [WIDTH-1:0] IV_DEF = WIDTH'(INTERVALO_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    estado_t          est_q [N_CANAIS];
    estado_t          est_d [N_CANAIS];
    logic [WIDTH-1:0] cnt_q [N_CANAIS];
    logic [WIDTH-1:0] cnt_d [N_CANAIS];
    logic [WIDTH-1:0] iv_q  [N_CANAIS];
    logic [WIDTH-1:0] iv_d  [N_CANAIS];
    logic [WIDTH-1:0] fim   [N_CANAIS];
    logic [PW-1:0]    pre_q [N_CANAIS];
    logic [PW-1:0]    pre_d [N_CANAIS];
    logic [N_CANAIS-1:0] modo_q, modo_d;
    logic [N_CANAIS-1:0] pulse_q, pulse_d;

    // Last count value of a period; an interval of 0 behaves as 1.
    always_comb begin
        for (int c = 0; c < N_CANAIS; c++) begin
            fim[c] = (iv_q[c] == '0) ? '0 : iv_q[c] - 1'b1;
        end
    end

    always_comb begin
        est_d   = est_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        iv_d    = iv_q;
        modo_d  = modo_q;
        pulse_d = '0;
        for (int c = 0; c < N_CANAIS; c++) begin
            if (stop[c]) begin
                est_d[c] = IDLE;
                cnt_d[c] = '0;
                pre_d[c] = '0;
            end else if (start[c]) begin
                est_d[c]  = RUN;
                cnt_d[c]  = '0;
                pre_d[c]  = '0;
                modo_d[c] = modo[c];
            end else if (est_q[c] == RUN) begin
                if (pre_q[c] == PRE_MAX) begin
                    pre_d[c] = '0;
                    // >= catches an interval shrunk below the running count
                    if (cnt_q[c] >= fim[c]) begin
                        pulse_d[c] = 1'b1;
                        if (modo_q[c]) begin
                            cnt_d[c] = '0;
                        end else begin
                            est_d[c] = DONE;
                        end
                    end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                    end
                end else begin
                    pre_d[c] = pre_q[c] + 1'b1;
                end
            end
            if (wr_en && (int'(wr_ch) == c)) begin
                iv_d[c] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CANAIS; c++) begin
                est_q[c] <= IDLE;
                cnt_q[c] <= '0;
                pre_q[c] <= '0;
                iv_q[c]  <= IV_DEF;
            end
            modo_q  <= '0;
            pulse_q <= '0;
        end else begin
            est_q   <= est_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            iv_q    <= iv_d;
            modo_q  <= modo_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        busy = '0;
        done = '0;
        for (int c = 0; c < N_CANAIS; c++) begin
            busy[c] = (est_q[c] == RUN);
            done[c] = (est_q[c] == DONE);
        end
    end

    assign pulse = pulse_q;

endmodule

// File: tb/tb_temporizador_multicanal.sv
// Directed plus randomized bench for temporizador_multicanal, checked
// every cycle against a cycle-count based reference model.
module tb_temporizador_multicanal;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int P   = 3;
    localparam int DEF = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] start = '0;
    logic [N-1:0] stop = '0;
    logic [N-1:0] modo = '0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_ch = '0;
    logic [W-1:0] wr_data = '0;
    logic [N-1:0] busy, done, pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Model: cycles since start, ticks since start/last expiry.
    bit m_run [N];
    bit m_per [N];
    bit m_done [N];
    bit m_pulse [N];
    int m_el [N];
    int m_tk [N];
    int m_iv [N];

    temporizador_multicanal #(
        .N_CANAIS(N), .WIDTH(W), .PRESC(P), .INTERVALO_DEF(DEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .modo(modo), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .busy(busy), .done(done), .pulse(pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_per[c] = 0; m_done[c] = 0; m_pulse[c] = 0;
            m_el[c] = 0; m_tk[c] = 0; m_iv[c] = DEF;
        end
    endtask

    task automatic model_edge();
        int eff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            m_pulse[c] = 0;
            if (stop[c]) begin
                m_run[c] = 0; m_done[c] = 0;
            end else if (start[c]) begin
                m_run[c] = 1; m_done[c] = 0; m_per[c] = modo[c];
                m_el[c] = 0; m_tk[c] = 0;
            end else if (m_run[c]) begin
                m_el[c]++;
                if (m_el[c] % P == 0) begin
                    m_tk[c]++;
                    eff = (m_iv[c] < 1) ? 1 : m_iv[c];
                    if (m_tk[c] >= eff) begin
                        m_pulse[c] = 1;
                        if (m_per[c]) m_tk[c] = 0;
                        else begin
                            m_run[c] = 0; m_done[c] = 1;
                        end
                    end
                end
            end
        end
        if (wr_en && int'(wr_ch) < N) m_iv[wr_ch] = int'(wr_data);
    endtask

    task automatic check_all(string tag);
        logic [N-1:0] eb, ed, ep;
        for (int c = 0; c < N; c++) begin
            eb[c] = m_run[c]; ed[c] = m_done[c]; ep[c] = m_pulse[c];
        end
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".pulse"}, 32'(pulse), 32'(ep));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("step");
        start = '0;
        stop  = '0;
        wr_en = 1'b0;
    endtask

    task automatic wr(int ch, int val);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_data = W'(val);
        step();
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset_async", 32'({busy, done, pulse}), 32'd0);
        step();
        step();
        check_all("reset");
        rst_n = 1'b1;
        step();

        // ch0 one-shot, I=3: pulse 9 cycles after start edge
        wr(0, 3);
        start = 3'b001; modo = 3'b000;
        step();
        repeat (8) step();
        chk("os_early", 32'(pulse[0]), 32'd0);
        step();
        chk("os_pulse", 32'(pulse[0]), 32'd1);
        chk("os_done", 32'(done[0]), 32'd1);
        chk("os_busy", 32'(busy[0]), 32'd0);
        step();
        chk("os_pulse_end", 32'(pulse[0]), 32'd0);
        chk("os_done_hold", 32'(done[0]), 32'd1);
        stop = 3'b001;
        step();
        chk("os_stop", 32'(done[0]), 32'd0);

        // ch1 periodic, I=2: pulses every 6 cycles, then stop
        wr(1, 2);
        start = 3'b010; modo = 3'b010;
        step();
        repeat (5) step();
        chk("per_early", 32'(pulse[1]), 32'd0);
        step();
        chk("per_p1", 32'(pulse[1]), 32'd1);
        repeat (6) step();
        chk("per_p2", 32'(pulse[1]), 32'd1);
        chk("per_done", 32'(done[1]), 32'd0);
        repeat (3) step();
        stop = 3'b010;
        step();
        chk("per_stop", 32'(busy[1]), 32'd0);
        repeat (6) step();

        // zero interval acts as 1; out-of-range channel write ignored
        wr(2, 0);
        wr(3, 1);
        start = 3'b100; modo = 3'b000;
        step();
        repeat (2) step();
        step();
        chk("zero_iv", 32'(pulse[2]), 32'd1);
        start = 3'b001; modo = 3'b000;
        step();
        repeat (9) step();
        chk("wr_ch3_ign", 32'(pulse[0]), 32'd1);

        // periodic I=10, shrink to 4 once cnt reaches 6
        wr(0, 10);
        start = 3'b001; modo = 3'b001;
        step();
        repeat (19) step();
        wr(0, 4);
        repeat (30) step();

        // start and stop together on a running channel
        start = 3'b001; stop = 3'b001;
        step();
        chk("start_stop", 32'(busy[0]), 32'd0);

        // start coincident with expiry restarts silently
        start = 3'b010; modo = 3'b010;
        step();
        repeat (5) step();
        start = 3'b010;
        step();
        chk("coinc_nopulse", 32'(pulse[1]), 32'd0);
        chk("coinc_busy", 32'(busy[1]), 32'd1);
        repeat (5) step();
        step();
        chk("coinc_next", 32'(pulse[1]), 32'd1);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            start = N'($urandom & $urandom & $urandom);
            stop  = N'($urandom & $urandom & $urandom & $urandom);
            modo  = N'($urandom);
            wr_en = ($urandom % 6) == 0;
            wr_ch = 2'($urandom);
            wr_data = W'($urandom_range(0, 6));
            step();
        end
        stop = '1;
        step();

        // asynchronous reset with done and busy set
        wr(0, 1);
        start = 3'b001; modo = 3'b000;
        step();
        step();
        start = 3'b110; modo = 3'b110;
        step();
        step();
        chk("pre_rst", 32'({busy, done}), 32'b110_001);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", 32'({busy, done, pulse}), 32'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        start = 3'b001; modo = 3'b000;
        step();
        repeat (14) step();
        step();
        chk("rst_def_iv", 32'(pulse[0]), 32'd1);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
